// File: rtl/clksw_req_ctrl.sv
// Initiator side of the HS/LS clock-switch handshake, clocked by hsclk_in.
// Optional handshake watchdog: define CLKSW_TIMEOUT_EN.
module clksw_req_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int LS_HOLD_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic       hsclk_in,
    input  logic       rst_b,
    input  logic       host_access_req,
    input  logic       hsclk_enable,
    input  logic       hsclk_selected,
    input  logic       lsclk_selected,
    output logic       hsclk_sel,
    output logic       rdy,
    output logic       in_hs_mode,
    output logic       switching,
    output logic [7:0] switch_count,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        LS_RUN = 2'd0,
        GO_HS  = 2'd1,
        HS_RUN = 2'd2,
        GO_LS  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(LS_HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if (SYNC_STAGES < 2 || (1 << CNT_W) <= LS_HOLD_CYCLES ||
        (1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_params
        $error("clksw_req_ctrl: SYNC_STAGES < 2 or CNT_W too narrow");
    end

    state_t                 state_q;
    logic                   hsclk_sel_q;
    logic [CNT_W-1:0]       dwell_q;
    logic [7:0]             count_q;
    logic [SYNC_STAGES-1:0] hs_sync_q;
    logic [SYNC_STAGES-1:0] ls_sync_q;
    logic                   hs_ack_s;
    logic                   ls_ack_s;
    logic                   wd_hit;

    // LS chain resets high to match the clock switch's own reset (LS selected).
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            hs_sync_q <= '0;
            ls_sync_q <= '1;
        end else begin
            hs_sync_q <= {hs_sync_q[SYNC_STAGES-2:0], hsclk_selected};
            ls_sync_q <= {ls_sync_q[SYNC_STAGES-2:0], lsclk_selected};
        end
    end

    assign hs_ack_s = hs_sync_q[SYNC_STAGES-1];
    assign ls_ack_s = ls_sync_q[SYNC_STAGES-1];

`ifdef CLKSW_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wd_q;
    logic             err_q;

    assign wd_hit = switching && ((wd_q + CNT_ONE) == TMO_LIMIT);

    // Watchdog is zero outside GO_x, so each entry starts from a clean count.
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else if (!switching) begin
            wd_q <= '0;
        end else if (wd_hit) begin
            err_q <= 1'b1;
            wd_q  <= (state_q == GO_HS) ? '0 : TMO_LIMIT;
        end else if (wd_q != TMO_LIMIT) begin
            wd_q <= wd_q + CNT_ONE;
        end
    end

    assign timeout_err = err_q;
`else
    assign wd_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= LS_RUN;
            hsclk_sel_q <= 1'b0;
            dwell_q     <= HOLD_LOAD;
            count_q     <= 8'd0;
        end else begin
            case (state_q)
                LS_RUN: begin
                    if (host_access_req) begin
                        dwell_q <= HOLD_LOAD;
                    end else if (dwell_q != '0) begin
                        dwell_q <= dwell_q - CNT_ONE;
                    end else if (hsclk_enable) begin
                        state_q     <= GO_HS;
                        hsclk_sel_q <= 1'b1;
                    end
                end
                // A pending host request never aborts an HS switch in flight.
                GO_HS: begin
                    if (hs_ack_s && !ls_ack_s) begin
                        state_q <= HS_RUN;
                        count_q <= count_q + 8'd1;
                    end else if (wd_hit) begin
                        state_q     <= GO_LS;
                        hsclk_sel_q <= 1'b0;
                    end
                end
                HS_RUN: begin
                    if (host_access_req || !hsclk_enable) begin
                        state_q     <= GO_LS;
                        hsclk_sel_q <= 1'b0;
                    end
                end
                GO_LS: begin
                    if (ls_ack_s && !hs_ack_s) begin
                        state_q <= LS_RUN;
                        dwell_q <= HOLD_LOAD;
                    end
                end
                default: begin
                    state_q     <= LS_RUN;
                    hsclk_sel_q <= 1'b0;
                end
            endcase
        end
    end

    assign hsclk_sel    = hsclk_sel_q;
    assign switch_count = count_q;
    assign in_hs_mode   = (state_q == HS_RUN);
    assign switching    = (state_q == GO_HS) || (state_q == GO_LS);
    assign rdy          = !(host_access_req && (state_q != LS_RUN));

endmodule

// File: doc/clksw_req_ctrl.md
Name: clksw_req_ctrl

Overview:
- Initiator side of the HS/LS clock-switch handshake.
- Drives hsclk_sel into the clock switch controller and waits for its hsclk_selected / lsclk_selected acknowledges, resynchronised into this block's clock domain.
- Holds the CPU (rdy low) while a host (LS) bus access waits for the LS clock, then returns to HS after a programmable dwell.
- Runs entirely on hsclk_in.

Parameters:
- SYNC_STAGES, 2: flops in each acknowledge synchroniser, minimum 2.
- LS_HOLD_CYCLES, 16: hsclk_in cycles to remain in LS after the last host access, before requesting HS.
- TIMEOUT_CYCLES, 1024: handshake watchdog limit, used only with CLKSW_TIMEOUT_EN.
- CNT_W, 11: width of the dwell and watchdog counters; must hold max(LS_HOLD_CYCLES, TIMEOUT_CYCLES).

Ports:
- hsclk_in, in, 1: sole clock, rising edge.
- rst_b, in, 1: asynchronous, active-low reset.
- host_access_req, in, 1: CPU cycle targets the host/LS bus (registered decode, hsclk_in domain).
- hsclk_enable, in, 1: turbo enable from configuration; 0 forces LS operation.
- hsclk_selected, in, 1: acknowledge from the clock switch, asynchronous.
- lsclk_selected, in, 1: acknowledge from the clock switch, asynchronous.
- hsclk_sel, out, 1: clock select request; 1 requests HS.
- rdy, out, 1: CPU ready; 0 stalls the CPU.
- in_hs_mode, out, 1: FSM is in HS_RUN.
- switching, out, 1: FSM is in GO_HS or GO_LS.
- switch_count, out, 8: completed LS->HS transitions, wraps 255->0.
- timeout_err, out, 1: sticky handshake timeout flag.

Behaviour:
- Reset (rst_b low, asynchronous):
  - FSM = LS_RUN, hsclk_sel = 0.
  - Dwell counter = LS_HOLD_CYCLES, watchdog = 0.
  - switch_count = 0, timeout_err = 0.
  - hs_ack_s synchroniser chain = 0; ls_ack_s chain = 1 (matches the switch's own reset state).
  - Resulting outputs: rdy = 1 when host_access_req = 0, in_hs_mode = 0, switching = 0.
- Synchronisers: hs_ack_s / ls_ack_s are the SYNC_STAGES-deep synchronised versions of hsclk_selected / lsclk_selected. The FSM uses only the synchronised versions.
- hsclk_sel is a registered output. It is 1 exactly in GO_HS and HS_RUN.
- LS_RUN:
  - host_access_req = 1: reload the dwell counter to LS_HOLD_CYCLES.
  - Otherwise, dwell counter decrements toward 0 and saturates at 0.
  - Go to GO_HS when dwell = 0, host_access_req = 0 and hsclk_enable = 1.
- GO_HS:
  - Wait for hs_ack_s = 1 and ls_ack_s = 0, then go to HS_RUN and increment switch_count.
  - A request arriving here does not abort the switch; the HS switch completes first, then HS_RUN exits immediately.
- HS_RUN: host_access_req = 1 or hsclk_enable = 0 -> GO_LS.
- GO_LS: wait for ls_ack_s = 1 and hs_ack_s = 0, then go to LS_RUN and reload the dwell counter.
- Latency: an acknowledge edge is seen by the FSM after SYNC_STAGES cycles; the state change happens on the next edge.
- rdy = !(host_access_req & (state != LS_RUN)). This is combinational from the registered state and the input.
- Both acknowledges high, or both low, during GO_x: keep waiting, no transition.
- hsclk_enable dropping during GO_HS: finish the switch to HS_RUN, then go to GO_LS.
- Reset asserted mid-switch: immediate return to LS_RUN / hsclk_sel = 0. The clock switch resets to LS simultaneously.

Optional Feature:
- Macro: CLKSW_TIMEOUT_EN.
- With the macro defined:
  - The watchdog clears on entry to GO_HS or GO_LS and increments each cycle in those states.
  - On reaching TIMEOUT_CYCLES, timeout_err is set (sticky until reset).
  - GO_HS timeout: go to GO_LS (hsclk_sel drops), falling back to LS.
  - GO_LS timeout: set the flag only and keep waiting.
- Without the macro: no watchdog logic; timeout_err is tied to 0; GO_x states wait indefinitely.

Test Plan:
- Reset, acknowledges hsclk_selected = 0 / lsclk_selected = 1, hsclk_enable = 1, no requests -> LS_RUN for 16 cycles, then hsclk_sel = 1. Model raises the HS ack after 5 cycles -> in_hs_mode = 1 at SYNC_STAGES + 1 cycles after the ack, switch_count = 1.
- In HS_RUN, assert host_access_req -> rdy = 0 the same cycle and hsclk_sel = 0 the next edge. Model swaps the acks after 7 cycles -> rdy = 1 three cycles later, in_hs_mode = 0.
- Host accesses pulsed every 10 cycles while in LS -> hsclk_sel stays 0. After the last access, hsclk_sel rises exactly 17 cycles later (16 dwell + transition).
- hsclk_enable = 0 from reset -> hsclk_sel = 0 indefinitely, switch_count = 0. Raising it to 1 -> HS request after the dwell.
- Request during GO_HS -> HS completes (switch_count increments), then immediate GO_LS; rdy stays 0 throughout.
- With CLKSW_TIMEOUT_EN and no HS ack -> after 1024 cycles timeout_err = 1 and hsclk_sel = 0. Without the macro -> timeout_err = 0 and the FSM stays in GO_HS.
